// File: rtl/bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_pkg : shared state encoding, bus constants and default widths
// Rev 1.0
// ----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_MWRITE = 3'd3,
    ST_MREAD  = 3'd4,
    ST_MWAIT  = 3'd5,
    ST_RDATA  = 3'd6
`ifdef SPLIT_EN
    , ST_SREQ = 3'd7
`endif
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int DEF_ADDR_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MEM_LATENCY = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_shift_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_shift_reg : right-shifting serial register (LSB out, new bit in at MSB)
// Rev 1.0
// ----------------------------------------------------------------------------
module bus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next,
  output logic             shift_out
);

  // data_next lets the owner grab the word in the same edge the last bit lands
  assign data_next = {shift_in, data[WIDTH-1:1]};
  assign shift_out = data[0];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (en) begin
      data <= data_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_slave_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_slave_port : serial-bus slave with one local memory access per transfer;
//                  define SPLIT_EN to release the bus during slow reads
// Rev 1.0
// ----------------------------------------------------------------------------
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic                  m_wdata,
  input  logic                  m_rw,
  output logic                  s_ready,
  output logic                  s_rvalid,
  output logic                  s_rdata,
  output logic                  s_split,
  output logic                  s_split_req,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SR_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W    = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, MEM_LATENCY) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             rw;
  logic             shift_en;
  logic             capture;
  logic             piso_shift;
  logic             piso_out;
  logic [SR_WIDTH-1:0]   sipo_next;
  logic [SR_WIDTH-1:0]   unused_sipo_q;
  logic                  unused_sipo_out;
  logic [DATA_WIDTH-1:0] unused_piso_q;
  logic [DATA_WIDTH-1:0] unused_piso_next;

  // Address then data enter at the MSB; a read stops after the address, so
  // the address ends up in the top ADDR_WIDTH bits in that case.
  bus_shift_reg #(.WIDTH(SR_WIDTH)) u_sipo (
    .clock     (clock),
    .rst       (rst),
    .en        (shift_en),
    .load      (1'b0),
    .load_data ({SR_WIDTH{1'b0}}),
    .shift_in  (m_wdata),
    .data      (unused_sipo_q),
    .data_next (sipo_next),
    .shift_out (unused_sipo_out)
  );

  bus_shift_reg #(.WIDTH(DATA_WIDTH)) u_piso (
    .clock     (clock),
    .rst       (rst),
    .en        (piso_shift),
    .load      (capture),
    .load_data (mem_rdata),
    .shift_in  (1'b0),
    .data      (unused_piso_q),
    .data_next (unused_piso_next),
    .shift_out (piso_out)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rw        <= RW_WRITE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            rw  <= m_rw;
            cnt <= CNT_W'(1);
          end
        end
        ST_ADDR: begin
          if (m_valid) begin
            if (cnt == ADDR_LAST) begin
              cnt <= '0;
              if (rw == RW_READ) begin
                mem_addr <= sipo_next[SR_WIDTH-1 -: ADDR_WIDTH];
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_WDATA: begin
          if (m_valid) begin
            if (cnt == DATA_LAST) begin
              cnt       <= '0;
              mem_addr  <= sipo_next[ADDR_WIDTH-1:0];
              mem_wdata <= sipo_next[SR_WIDTH-1 -: DATA_WIDTH];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_MWAIT: cnt <= capture ? '0 : cnt + CNT_W'(1);
        ST_RDATA: cnt <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    s_ready     = 1'b0;
    s_rvalid    = 1'b0;
    s_rdata     = 1'b0;
    s_split     = 1'b0;
    s_split_req = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    shift_en    = 1'b0;
    capture     = 1'b0;
    piso_shift  = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready  = 1'b1;
        shift_en = m_valid;
        if (m_valid) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        shift_en = m_valid;
        if (m_valid && cnt == ADDR_LAST)
          state_next = (rw == RW_READ) ? ST_MREAD : ST_WDATA;
      end
      ST_WDATA: begin
        shift_en = m_valid;
        if (m_valid && cnt == DATA_LAST) state_next = ST_MWRITE;
      end
      ST_MWRITE: begin
        mem_we     = 1'b1;
        state_next = ST_IDLE;
      end
      ST_MREAD: begin
        mem_re     = 1'b1;
`ifdef SPLIT_EN
        s_split    = 1'b1;
`endif
        state_next = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (cnt == WAIT_LAST) begin
          capture    = 1'b1;
`ifdef SPLIT_EN
          state_next = ST_SREQ;
`else
          state_next = ST_RDATA;
`endif
        end
      end
`ifdef SPLIT_EN
      ST_SREQ: begin
        s_split_req = 1'b1;
        if (split_grant) state_next = ST_RDATA;
      end
`endif
      ST_RDATA: begin
        s_rvalid   = 1'b1;
        s_rdata    = piso_out;
        piso_shift = 1'b1;
        if (cnt == DATA_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifndef SPLIT_EN
  logic unused_split_grant;
  assign unused_split_grant = split_grant;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bus_slave_port : vector table plus random transfers against a timeline model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bus_slave_port;
  import bus_pkg::*;

  localparam int A = 12;
  localparam int D = 8;
  localparam int L = 2;
`ifdef SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         rst;
  logic         m_valid, m_wdata, m_rw, split_grant;
  logic         s_ready, s_rvalid, s_rdata, s_split, s_split_req;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_wdata, mem_rdata;
  logic         mem_we, mem_re;

  always #5 clock = ~clock;

  bus_slave_port #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .MEM_LATENCY(L)) dut (
    .clock(clock), .rst(rst), .m_valid(m_valid), .m_wdata(m_wdata), .m_rw(m_rw),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_split(s_split),
    .s_split_req(s_split_req), .split_grant(split_grant), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] mem_init(input logic [11:0] a);
    return 8'h36 ^ a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  // Memory responder with L cycles of read latency; garbage when not reading.
  logic [7:0] dut_mem [0:4095];
  logic [7:0] pipe [L];
  bit         inited = 1'b0;
  always @(posedge clock) begin
    if (!inited) begin
      for (int i = 0; i < 4096; i++) dut_mem[i] <= mem_init(12'(i));
      inited <= 1'b1;
    end else if (mem_we) begin
      dut_mem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= mem_re ? dut_mem[mem_addr] : 8'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[L-1];

  logic [7:0] ref_mem [logic [11:0]];
  function automatic logic [7:0] ref_rd(input logic [11:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [6:0] outs();
    return {s_ready, s_rvalid, s_rdata, mem_we, mem_re, s_split, s_split_req};
  endfunction

  // One transfer; cycle 0 is the first address bit. Expected outputs come from
  // the bit schedule: last bit at T, strobe at T+1, read data L cycles later.
  task automatic run_txn(input string name, input logic rw, input logic [11:0] addr,
                         input logic [7:0] wdata, input int gap, input logic [7:0] exp_rd,
                         input int base_done, input int grant_dly, input int abort_bit);
    logic [19:0] bits;
    int nbits, t_last, sreq_lo, sreq_hi, rstart, done;
    logic [6:0] ev;
    bits    = {wdata, addr};
    nbits   = (rw == RW_READ) ? A : A + D;
    t_last  = (nbits - 1) * (gap + 1);
    sreq_lo = t_last + 2 + L;
    sreq_hi = sreq_lo + grant_dly;
    rstart  = sreq_lo + (SPLIT ? grant_dly + 1 : 0);
    done    = base_done + ((SPLIT && rw == RW_READ) ? grant_dly + 1 : 0);
    for (int k = 0; k <= done; k++) begin
      bit on_bit, e_rv;
      on_bit = (k % (gap + 1) == 0) && (k / (gap + 1) < nbits);
      if (k <= t_last) begin
        m_valid = on_bit;
        m_wdata = on_bit ? bits[k / (gap + 1)] : 1'($urandom_range(0, 1));
      end else if (k < done) begin
        m_valid = 1'($urandom_range(0, 1));
        m_wdata = 1'($urandom_range(0, 1));
      end else begin
        m_valid = 1'b0;
      end
      m_rw = (k == 0) ? rw : 1'($urandom_range(0, 1));
      if (rw == RW_READ && k >= sreq_lo && k < sreq_hi) split_grant = 1'b0;
      else if (rw == RW_READ && k == sreq_hi)           split_grant = 1'b1;
      else                                               split_grant = 1'($urandom_range(0, 1));
      @(negedge clock);
      e_rv = (rw == RW_READ) && k >= rstart && k < rstart + D;
      ev = {(k == 0) || (k >= done), e_rv, e_rv ? exp_rd[(k - rstart) % D] : 1'b0,
            (rw == RW_WRITE) && k == t_last + 1, (rw == RW_READ) && k == t_last + 1,
            SPLIT && (rw == RW_READ) && k == t_last + 1,
            SPLIT && (rw == RW_READ) && k >= sreq_lo && k <= sreq_hi};
      chk($sformatf("%s c%0d outputs", name, k), 32'(outs()), 32'(ev));
      if (ev[3] || ev[2]) chk($sformatf("%s c%0d mem_addr", name, k), 32'(mem_addr), 32'(addr));
      if (ev[3]) chk($sformatf("%s c%0d mem_wdata", name, k), 32'(mem_wdata), 32'(wdata));
      if (k == done) chk($sformatf("%s hold mem_addr", name), 32'(mem_addr), 32'(addr));
      if (abort_bit >= 0 && k == rstart + abort_bit) begin
        rst = 1'b1;
        #1;
        chk($sformatf("%s reset outputs", name), 32'(outs()), 32'h40);
        #1 rst = 1'b0;
        m_valid = 1'b0;
        @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
      #1;
    end
  endtask

  typedef struct {
    string      name;
    logic       rw;
    logic [11:0] addr;
    logic [7:0] wdata;
    int         gap;
    logic [7:0] exp_rd;
    int         done;
    int         grant_dly;
    int         abort_bit;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{"wr012",     RW_WRITE, 12'h012, 8'hA5, 0, 8'h00, 21, 0, -1};
    tbl[1] = '{"wr012_gap", RW_WRITE, 12'h012, 8'hA5, 3, 8'h00, 78, 0, -1};
    tbl[2] = '{"rd00A",     RW_READ,  12'h00A, 8'h00, 0, 8'h3C, 23, 10, -1};
    tbl[3] = '{"rd012",     RW_READ,  12'h012, 8'h00, 0, 8'hA5, 23, 0, -1};
    tbl[4] = '{"rd_abort",  RW_READ,  12'h00A, 8'h00, 0, 8'h3C, 23, 2, 3};
    tbl[5] = '{"wr001",     RW_WRITE, 12'h001, 8'hFF, 0, 8'h00, 21, 0, -1};
    tbl[6] = '{"rd001_gap", RW_READ,  12'h001, 8'h00, 1, 8'hFF, 34, 1, -1};

    rst = 1'b1; m_valid = 1'b0; m_wdata = 1'b0; m_rw = 1'b0; split_grant = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset outputs", 32'(outs()), 32'h40);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      split_grant = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk($sformatf("idle c%0d outputs", i), 32'(outs()), 32'h40);
    end
    @(posedge clock);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].name, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].gap,
              tbl[i].exp_rd, tbl[i].done, tbl[i].grant_dly, tbl[i].abort_bit);
      if (tbl[i].rw == RW_WRITE) ref_mem[tbl[i].addr] = tbl[i].wdata;
    end

    for (int n = 0; n < 40; n++) begin
      logic        rw;
      logic [11:0] addr;
      logic [7:0]  wd;
      int          gap, g, done;
      rw   = 1'($urandom_range(0, 1));
      addr = 12'($urandom_range(0, 15));
      wd   = 8'($urandom);
      gap  = $urandom_range(0, 2);
      g    = $urandom_range(0, 4);
      done = (rw == RW_READ) ? (A - 1) * (gap + 1) + 2 + L + D : (A + D - 1) * (gap + 1) + 2;
      run_txn($sformatf("rand%0d", n), rw, addr, wd, gap, ref_rd(addr), done, g, -1);
      if (rw == RW_WRITE) ref_mem[addr] = wd;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
